// File: rtl/dcache_write_buffer_pkg.sv
// rtl/dcache_write_buffer_pkg.sv - shared sizes and drain-FSM encoding for the dcache write buffer
package dcache_write_buffer_pkg;

    localparam int WB_WORD_SIZE   = 32;
    localparam int WB_DEPTH       = 4;
    localparam int WB_DEPTH_INDEX = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/dcache_write_buffer_forward_match.sv
// rtl/dcache_write_buffer_forward_match.sv - DEPTH-way address compare with youngest-entry priority
import dcache_write_buffer_pkg::*;

module wb_forward_match #(
    parameter int WORD_SIZE   = WB_WORD_SIZE,
    parameter int DEPTH       = WB_DEPTH,
    parameter int DEPTH_INDEX = WB_DEPTH_INDEX
) (
    input  logic [WORD_SIZE-1:0]   entry_addr [DEPTH],
    input  logic [WORD_SIZE-1:0]   entry_data [DEPTH],
    input  logic [DEPTH-1:0]       entry_valid,
    input  logic [DEPTH_INDEX-1:0] wr_ptr,
    input  logic [WORD_SIZE-1:0]   lookup_addr,
    output logic                   hit,
    output logic [WORD_SIZE-1:0]   data
);

    logic [DEPTH_INDEX-1:0] idx;

    // Walk from oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = wr_ptr - DEPTH_INDEX'(1) - DEPTH_INDEX'(k);
            if (entry_valid[idx] && (entry_addr[idx] == lookup_addr)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - in-order store FIFO between ROB commit and dcache with load forwarding
import dcache_write_buffer_pkg::*;

module dcache_write_buffer #(
    parameter int WORD_SIZE   = WB_WORD_SIZE,
    parameter int DEPTH       = WB_DEPTH,
    parameter int DEPTH_INDEX = WB_DEPTH_INDEX
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_mem,
    input  logic [WORD_SIZE-1:0]   wd_mem,
    input  logic [WORD_SIZE-1:0]   ws_mem,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_INDEX:0]   count,
    output logic                   overflow,
    output logic                   mem_req,
    output logic [WORD_SIZE-1:0]   mem_addr,
    output logic [WORD_SIZE-1:0]   mem_data,
    input  logic                   mem_ack,
    input  logic [WORD_SIZE-1:0]   lookup_addr,
    output logic                   lookup_hit,
    output logic [WORD_SIZE-1:0]   lookup_data
);

    localparam logic [DEPTH_INDEX:0] DEPTH_CNT = (DEPTH_INDEX + 1)'(DEPTH);

    logic [WORD_SIZE-1:0]   addr_q [DEPTH];
    logic [WORD_SIZE-1:0]   data_q [DEPTH];
    logic [DEPTH_INDEX-1:0] wr_ptr;
    logic [DEPTH_INDEX-1:0] rd_ptr;
    wb_state_e              state;

    logic                   push;
    logic                   pop;
    logic [DEPTH_INDEX:0]   count_next;
    logic [DEPTH_INDEX:0]   remaining;
    logic [DEPTH_INDEX-1:0] rd_next;
    logic [WORD_SIZE-1:0]   head_addr_next;
    logic [WORD_SIZE-1:0]   head_data_next;
    logic [DEPTH-1:0]       entry_valid;

    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);
    assign mem_req    = (state == ST_REQ);
    assign push       = we_mem & ~full;
    assign pop        = (state == ST_REQ) & mem_ack;
    assign remaining  = count - (DEPTH_INDEX + 1)'(pop);
    assign count_next = remaining + (DEPTH_INDEX + 1)'(push);
    assign rd_next    = rd_ptr + DEPTH_INDEX'(pop);

    // Head for the next cycle; if the FIFO drains to nothing this edge, the incoming store becomes head.
    always_comb begin
        head_addr_next = '0;
        head_data_next = '0;
        if (count_next != '0) begin
            if (remaining == '0) begin
                head_addr_next = ws_mem;
                head_data_next = wd_mem;
            end else begin
                head_addr_next = addr_q[rd_next];
                head_data_next = data_q[rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= ws_mem;
            data_q[wr_ptr] <= wd_mem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= ST_IDLE;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_INDEX'(1);
            end
            if (we_mem && full) begin
                overflow <= 1'b1;
            end
            rd_ptr   <= rd_next;
            count    <= count_next;
            state    <= (count_next != '0) ? ST_REQ : ST_IDLE;
            mem_addr <= head_addr_next;
            mem_data <= head_data_next;
        end
    end

    // Entry i is live when its distance from the head is below the occupancy.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, DEPTH_INDEX'(i) - rd_ptr} < count);
        end
    end

    wb_forward_match #(
        .WORD_SIZE   (WORD_SIZE),
        .DEPTH       (DEPTH),
        .DEPTH_INDEX (DEPTH_INDEX)
    ) u_forward (
        .entry_addr  (addr_q),
        .entry_data  (data_q),
        .entry_valid (entry_valid),
        .wr_ptr      (wr_ptr),
        .lookup_addr (lookup_addr),
        .hit         (lookup_hit),
        .data        (lookup_data)
    );

endmodule
